// File: rtl/hilo_muldiv_sequencer.sv
// hilo_muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU engine that owns the
// architectural HI/LO registers and serves MTHI/MTLO/MFHI/MFLO.
// Magnitudes are multiplied (radix-2 shift-add) or divided (restoring), and
// the signs are applied in a single fixup cycle at the end.
// Optional: define MULDIV_EARLY_OUT_EN to leave MUL as soon as the remaining
// multiplier magnitude is zero.
module hilo_muldiv_sequencer #(
    parameter int ITERS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        op_valid,
    input  logic [5:0]  op_code,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] mf_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int N_IT  = 32 / ITERS_PER_CYCLE;
    localparam int CNT_W = 6;

    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MFLO  = 6'b010010;
    localparam logic [5:0] OP_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIXUP
    } state_t;

    state_t state, next_state;

    logic [CNT_W-1:0] counter;
    logic [63:0]      acc;        // product, or {remainder, quotient} while dividing
    logic [63:0]      mcand;      // shifted multiplicand magnitude
    logic [31:0]      opb;        // remaining multiplier, or divisor magnitude
    logic             sign_a;
    logic             sign_b;
    logic             is_div_r;

    logic is_mul_op, is_div_op, is_signed_op, is_mf_op, is_mt_op;
    logic start_mul, start_div, write_hi, write_lo;
    logic last_iter, early_out;
    logic [31:0] mag_a, mag_b;

    logic [63:0] step_acc, step_mcand;
    logic [31:0] step_mplier;
    logic [32:0] rem_t;
    logic [31:0] quo_t;

    logic [31:0] fix_hi, fix_lo;
    logic [63:0] neg_acc;

    assign is_mul_op    = (op_code == OP_MULT) || (op_code == OP_MULTU);
    assign is_div_op    = (op_code == OP_DIV)  || (op_code == OP_DIVU);
    assign is_signed_op = (op_code == OP_MULT) || (op_code == OP_DIV);
    assign is_mf_op     = (op_code == OP_MFHI) || (op_code == OP_MFLO);
    assign is_mt_op     = (op_code == OP_MTHI) || (op_code == OP_MTLO);

    assign mag_a = (is_signed_op && operand_a[31]) ? -operand_a : operand_a;
    assign mag_b = (is_signed_op && operand_b[31]) ? -operand_b : operand_b;

    assign last_iter = (counter == CNT_W'(N_IT - 1));

`ifdef MULDIV_EARLY_OUT_EN
    assign early_out = (opb == '0);
`else
    assign early_out = 1'b0;
`endif

    assign busy  = (state != S_IDLE);
    assign stall = op_valid && busy && (is_mul_op || is_div_op || is_mf_op || is_mt_op);

    // MFHI/MFLO read the architectural registers directly
    always_comb begin
        mf_data = '0;
        if (op_valid && op_code == OP_MFHI) begin
            mf_data = hi;
        end else if (op_valid && op_code == OP_MFLO) begin
            mf_data = lo;
        end
    end

    // One cycle worth of shift-add or restoring-divide steps on the magnitudes
    always_comb begin
        step_acc    = acc;
        step_mcand  = mcand;
        step_mplier = opb;
        rem_t       = '0;
        quo_t       = '0;
        for (int i = 0; i < ITERS_PER_CYCLE; i++) begin
            if (is_div_r) begin
                rem_t = {step_acc[63:32], step_acc[31]};
                quo_t = {step_acc[30:0], 1'b0};
                if (rem_t >= {1'b0, opb}) begin
                    rem_t    = rem_t - {1'b0, opb};
                    quo_t[0] = 1'b1;
                end
                step_acc = {rem_t[31:0], quo_t};
            end else begin
                if (step_mplier[0]) begin
                    step_acc = step_acc + step_mcand;
                end
                step_mcand  = step_mcand << 1;
                step_mplier = step_mplier >> 1;
            end
        end
    end

    // Sign fixup: negate product/quotient on differing signs, remainder follows dividend
    always_comb begin
        neg_acc = -acc;
        fix_hi  = acc[63:32];
        fix_lo  = acc[31:0];
        if (is_div_r) begin
            if (sign_a ^ sign_b) begin
                fix_lo = -acc[31:0];
            end
            if (sign_a) begin
                fix_hi = -acc[63:32];
            end
        end else if (sign_a ^ sign_b) begin
            fix_hi = neg_acc[63:32];
            fix_lo = neg_acc[31:0];
        end
    end

    // Next-state and control decode; flush always wins over a new op
    always_comb begin
        next_state  = state;
        start_mul   = 1'b0;
        start_div   = 1'b0;
        write_hi    = 1'b0;
        write_lo    = 1'b0;
        done        = 1'b0;
        div_by_zero = 1'b0;
        case (state)
            S_IDLE: begin
                if (op_valid && !flush) begin
                    if (is_mul_op) begin
                        next_state = S_MUL;
                        start_mul  = 1'b1;
                    end else if (is_div_op) begin
                        if (operand_b == '0) begin
                            div_by_zero = 1'b1;
                        end else begin
                            next_state = S_DIV;
                            start_div  = 1'b1;
                        end
                    end else if (op_code == OP_MTHI) begin
                        write_hi = 1'b1;
                    end else if (op_code == OP_MTLO) begin
                        write_lo = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (flush) begin
                    next_state = S_IDLE;
                end else if (early_out || last_iter) begin
                    next_state = S_FIXUP;
                end
            end
            S_DIV: begin
                if (flush) begin
                    next_state = S_IDLE;
                end else if (last_iter) begin
                    next_state = S_FIXUP;
                end
            end
            S_FIXUP: begin
                next_state = S_IDLE;
                done       = !flush;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Operand latch, iteration registers and HI/LO updates
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hi       <= '0;
            lo       <= '0;
            acc      <= '0;
            mcand    <= '0;
            opb      <= '0;
            counter  <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            is_div_r <= 1'b0;
        end else begin
            if (start_mul || start_div) begin
                counter  <= '0;
                sign_a   <= is_signed_op && operand_a[31];
                sign_b   <= is_signed_op && operand_b[31];
                is_div_r <= start_div;
                opb      <= mag_b;
                mcand    <= {32'b0, mag_a};
                acc      <= start_div ? {32'b0, mag_a} : 64'b0;
            end else if ((state == S_MUL || state == S_DIV) && !flush) begin
                acc     <= step_acc;
                mcand   <= step_mcand;
                opb     <= step_mplier;
                counter <= counter + CNT_W'(1);
            end
            if (write_hi) begin
                hi <= operand_a;
            end
            if (write_lo) begin
                lo <= operand_a;
            end
            if (done) begin
                hi <= fix_hi;
                lo <= fix_lo;
            end
        end
    end

endmodule
